// File: rtl/godson_apb_pkg.sv
// Shared definitions for the APB master bridge.
//   apb_state_e : bridge FSM states (IDLE, SETUP, ACCESS, RESP)
//   SEL_LSB/MSB : address field that picks the target slave
//   SLV_NUM     : number of slave select lines
//   slave_sel() : one-hot decode of the slave field
package godson_apb_pkg;

    localparam int unsigned SEL_LSB = 16;
    localparam int unsigned SEL_MSB = 18;
    localparam int unsigned SEL_W   = SEL_MSB - SEL_LSB + 1;
    localparam int unsigned SLV_NUM = 8;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2,
        StResp   = 2'd3
    } apb_state_e;

    function automatic logic [SLV_NUM-1:0] slave_sel(input logic [SEL_W-1:0] idx);
        logic [SLV_NUM-1:0] one;
        one = {{(SLV_NUM - 1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/apb_master_bridge.sv
// Single-outstanding command-to-APB3 master bridge.
// Ports:
//   apb_pclk, rst               : clock, asynchronous active-high reset
//   cmd_valid/ready/write/addr/wdata : command channel (accepted only in IDLE)
//   rsp_valid/ready/rdata/err   : response channel (held in RESP until consumed)
//   apb_psel/paddr/pwrite/penable/pwdata : APB request outputs
//   apb_prdata/pready/pslverr   : APB completion inputs
// A wait counter aborts an ACCESS phase after TIMEOUT stalled cycles (0 disables).
module apb_master_bridge
    import godson_apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               apb_pclk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [ADDR_W-1:0]  cmd_addr,
    input  logic [DATA_W-1:0]  cmd_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_rdata,
    output logic               rsp_err,
    output logic [SLV_NUM-1:0] apb_psel,
    output logic [ADDR_W-1:0]  apb_paddr,
    output logic               apb_pwrite,
    output logic               apb_penable,
    output logic [DATA_W-1:0]  apb_pwdata,
    input  logic [DATA_W-1:0]  apb_prdata,
    input  logic               apb_pready,
    input  logic               apb_pslverr
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    apb_state_e          r_state;
    apb_state_e          w_state_next;
    logic [ADDR_W-1:0]   r_paddr;
    logic                r_pwrite;
    logic [DATA_W-1:0]   r_pwdata;
    logic [CNT_W-1:0]    r_wait_cnt;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;

    logic                w_cmd_fire;
    logic [CNT_W:0]      w_wait_inc;
    logic                w_timeout;
    logic                w_rsp_load;
    logic [DATA_W-1:0]   w_rsp_rdata;
    logic                w_rsp_err;
    logic [SLV_NUM-1:0]  w_psel;

    assign cmd_ready   = (r_state == StIdle) && !rst;
    assign w_cmd_fire  = cmd_valid && cmd_ready;

    // Extra top bit flags the counter is at all-ones, so it saturates instead of wrapping.
    assign w_wait_inc  = {1'b0, r_wait_cnt} + (CNT_W + 1)'(1);
    // Fires when this stalled cycle would bring the count up to TIMEOUT.
    assign w_timeout   = (TIMEOUT != 0) && (w_wait_inc == (CNT_W + 1)'(TIMEOUT));

    always_comb begin
        w_state_next = r_state;
        w_rsp_load   = 1'b0;
        w_rsp_rdata  = '0;
        w_rsp_err    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_cmd_fire) w_state_next = StSetup;
            end
            StSetup: begin
                w_state_next = StAccess;
            end
            StAccess: begin
                // pready takes priority over a timeout in the same cycle.
                if (apb_pready) begin
                    w_rsp_load   = 1'b1;
                    w_rsp_err    = apb_pslverr;
                    w_rsp_rdata  = (!r_pwrite && !apb_pslverr) ? apb_prdata : '0;
                    w_state_next = StResp;
                end else if (w_timeout) begin
                    w_rsp_load   = 1'b1;
                    w_rsp_err    = 1'b1;
                    w_state_next = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge apb_pclk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_wait_cnt  <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_cmd_fire) begin
                r_paddr    <= cmd_addr;
                r_pwrite   <= cmd_write;
                r_pwdata   <= cmd_wdata;
                r_wait_cnt <= '0;
            end else if (r_state == StAccess && !apb_pready && !w_wait_inc[CNT_W]) begin
                r_wait_cnt <= w_wait_inc[CNT_W-1:0];
            end
            if (w_rsp_load) begin
                r_rsp_rdata <= w_rsp_rdata;
                r_rsp_err   <= w_rsp_err;
            end
        end
    end

    // Select is decoded from state, so reset drops it without waiting for a clock.
    always_comb begin
        w_psel = '0;
        if (r_state == StSetup || r_state == StAccess) begin
            w_psel = slave_sel(r_paddr[SEL_MSB:SEL_LSB]);
        end
    end

    assign apb_psel    = w_psel;
    assign apb_penable = (r_state == StAccess);
    assign apb_paddr   = r_paddr;
    assign apb_pwrite  = r_pwrite;
    assign apb_pwdata  = r_pwdata;
    assign rsp_valid   = (r_state == StResp);
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed vector table plus
// randomized transactions checked against a transaction-level model.
module tb_apb_master_bridge;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [7:0]  apb_psel;
    logic [31:0] apb_paddr, apb_pwdata, apb_prdata;
    logic        apb_pwrite, apb_penable, apb_pready, apb_pslverr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    apb_master_bridge #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TMO)
    ) dut (
        .apb_pclk   (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .apb_psel   (apb_psel),
        .apb_paddr  (apb_paddr),
        .apb_pwrite (apb_pwrite),
        .apb_penable(apb_penable),
        .apb_pwdata (apb_pwdata),
        .apb_prdata (apb_prdata),
        .apb_pready (apb_pready),
        .apb_pslverr(apb_pslverr)
    );

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;      // pready-low cycles before the slave answers
        logic        slverr;
        logic [31:0] prdata;
        int          rsp_delay;  // cycles rsp_ready is held low in RESP
        logic [7:0]  exp_psel;
        int          exp_access; // ACCESS-phase length in cycles
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] wd,
                                input int waits, input logic se, input logic [31:0] rd,
                                input int dly, input logic [7:0] psel, input int acc,
                                input logic err, input logic [31:0] rdata);
        vec_t v;
        v.write = w; v.addr = a; v.wdata = wd; v.waits = waits; v.slverr = se;
        v.prdata = rd; v.rsp_delay = dly; v.exp_psel = psel; v.exp_access = acc;
        v.exp_err = err; v.exp_rdata = rdata;
        return v;
    endfunction

    // Transaction-level reference: outcome depends only on how long the slave stalls.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        logic timed_out;
        r = v;
        timed_out    = (v.waits >= int'(TMO));
        r.exp_access = timed_out ? int'(TMO) : v.waits + 1;
        r.exp_err    = timed_out || v.slverr;
        r.exp_rdata  = (v.write || r.exp_err) ? 32'h0 : v.prdata;
        r.exp_psel   = 8'd1 << v.addr[18:16];
        return r;
    endfunction

    // Starts and ends at a point between clock edges with the DUT in IDLE.
    task automatic run_txn(input vec_t v);
        int acc;
        bit done;
        chk("idle_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("idle_psel", 64'(apb_psel), 64'(0));
        cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr; cmd_wdata = v.wdata;
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0; cmd_write = ~v.write; cmd_addr = $urandom; cmd_wdata = $urandom;
        chk("setup_psel", 64'(apb_psel), 64'(v.exp_psel));
        chk("setup_penable", 64'(apb_penable), 64'(0));
        chk("setup_paddr", 64'(apb_paddr), 64'(v.addr));
        chk("setup_pwrite", 64'(apb_pwrite), 64'(v.write));
        chk("setup_pwdata", 64'(apb_pwdata), 64'(v.wdata));
        chk("setup_cmd_ready", 64'(cmd_ready), 64'(0));
        acc = 0;
        done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(posedge clk); @(negedge clk);
            if (!apb_penable) begin
                done = 1'b1;
            end else begin
                acc++;
                chk("access_psel", 64'(apb_psel), 64'(v.exp_psel));
                chk("access_paddr", 64'(apb_paddr), 64'(v.addr));
                chk("access_pwrite", 64'(apb_pwrite), 64'(v.write));
                chk("access_pwdata", 64'(apb_pwdata), 64'(v.wdata));
                chk("access_cmd_ready", 64'(cmd_ready), 64'(0));
                apb_pready  = (acc == v.waits + 1);
                apb_pslverr = apb_pready ? v.slverr : 1'($urandom_range(0, 1));
                apb_prdata  = v.prdata;
            end
        end
        apb_pready = 1'b0; apb_pslverr = 1'b0; apb_prdata = $urandom;
        chk("access_ended", 64'(done), 64'(1));
        chk("access_cycles", 64'(acc), 64'(v.exp_access));
        chk("resp_valid", 64'(rsp_valid), 64'(1));
        chk("resp_psel", 64'(apb_psel), 64'(0));
        chk("resp_penable", 64'(apb_penable), 64'(0));
        chk("resp_err", 64'(rsp_err), 64'(v.exp_err));
        chk("resp_rdata", 64'(rsp_rdata), 64'(v.exp_rdata));
        chk("resp_cmd_ready", 64'(cmd_ready), 64'(0));
        for (int d = 0; d < v.rsp_delay; d++) begin
            cmd_valid = 1'b1;  // must be ignored while a response is pending
            @(posedge clk); @(negedge clk);
            chk("hold_valid", 64'(rsp_valid), 64'(1));
            chk("hold_err", 64'(rsp_err), 64'(v.exp_err));
            chk("hold_rdata", 64'(rsp_rdata), 64'(v.exp_rdata));
            chk("hold_cmd_ready", 64'(cmd_ready), 64'(0));
            chk("hold_psel", 64'(apb_psel), 64'(0));
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        rsp_ready = 1'b0;
        chk("done_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("done_cmd_ready", 64'(cmd_ready), 64'(1));
    endtask

    vec_t tbl[7];
    vec_t rv;

    initial begin
        // Directed vectors (TIMEOUT = 4).
        // 0xBFEC_0004 selects slave 4, 0xBFED_0000 slave 5.
        tbl[0] = mk(1'b1, 32'hBFEC_0004, 32'h0000_00A5, 0, 1'b0, 32'h0BAD_0BAD, 0,
                    8'h10, 1, 1'b0, 32'h0);
        // Three stalls then ready on the cycle the timeout would fire: pready wins.
        tbl[1] = mk(1'b0, 32'hBFED_0000, 32'h0, 3, 1'b0, 32'h1234_5678, 1,
                    8'h20, 4, 1'b0, 32'h1234_5678);
        tbl[2] = mk(1'b0, 32'h0000_0000, 32'h0, 10, 1'b0, 32'hDEAD_BEEF, 0,
                    8'h01, 4, 1'b1, 32'h0);
        tbl[3] = mk(1'b0, 32'h0002_0100, 32'h0, 0, 1'b1, 32'hCAFE_F00D, 5,
                    8'h04, 1, 1'b1, 32'h0);
        tbl[4] = mk(1'b0, 32'h0007_0010, 32'h0, 0, 1'b0, 32'h55AA_55AA, 2,
                    8'h80, 1, 1'b0, 32'h55AA_55AA);
        tbl[5] = mk(1'b1, 32'h0001_0000, 32'h1357_9BDF, 2, 1'b1, 32'hFFFF_FFFF, 0,
                    8'h02, 3, 1'b1, 32'h0);
        tbl[6] = mk(1'b1, 32'hFFFB_FFFC, 32'h2468_ACE0, 4, 1'b0, 32'h0, 1,
                    8'h08, 4, 1'b1, 32'h0);

        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; apb_prdata = '0; apb_pready = 1'b0; apb_pslverr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
        chk("rst_psel", 64'(apb_psel), 64'(0));
        chk("rst_penable", 64'(apb_penable), 64'(0));
        chk("rst_paddr", 64'(apb_paddr), 64'(0));
        chk("rst_pwrite", 64'(apb_pwrite), 64'(0));
        chk("rst_pwdata", 64'(apb_pwdata), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        chk("rst_rsp_err", 64'(rsp_err), 64'(0));
        rst = 1'b0;
        #1;
        chk("rel_cmd_ready", 64'(cmd_ready), 64'(1));

        for (int i = 0; i < 7; i++) run_txn(tbl[i]);

        for (int i = 0; i < 40; i++) begin
            rv.write     = 1'($urandom_range(0, 1));
            rv.addr      = $urandom;
            rv.wdata     = $urandom;
            rv.waits     = int'($urandom_range(0, 6));
            rv.slverr    = ($urandom_range(0, 3) == 0);
            rv.prdata    = $urandom;
            rv.rsp_delay = int'($urandom_range(0, 3));
            run_txn(model(rv));
        end

        // Reset during ACCESS.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0003_0040;
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("pre_rst_penable", 64'(apb_penable), 64'(1));
        #2 rst = 1'b1;
        #1;
        chk("midrst_psel", 64'(apb_psel), 64'(0));
        chk("midrst_penable", 64'(apb_penable), 64'(0));
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("midrst_cmd_ready", 64'(cmd_ready), 64'(0));
        chk("midrst_paddr", 64'(apb_paddr), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_rel_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("midrst_rel_rsp_valid", 64'(rsp_valid), 64'(0));
        run_txn(tbl[4]);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
